key_watchdog_ctrl: RTL and testbench

//  Parametrised licence watchdog and successor to the single-rate DNA watchdog.
//  - Serial key stream: sclk/sdat/en from the board MCU, sampled on clk.
//  - A valid key refreshes the timeout; each missed window fires a reset pulse and counts a strike.
//  - After MAX_STRIKES consecutive strikes the block locks reset asserted until rst.

---
 rtl/key_watchdog_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_key_watchdog_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_watchdog_ctrl.sv
// key_watchdog_ctrl
//   Licence watchdog. The board MCU shifts a key in over a slow serial link
//   (sclk/sdat/en). When the low KEY_BITS of the shift register match the
//   device ID, the timeout window is refreshed. Each full window without a
//   match raises a wd_reset pulse and counts one strike. After MAX_STRIKES
//   consecutive strikes, wd_reset is held high until rst.
//
// Ports
//   clk        in   system clock, all logic
//   rst        in   synchronous active-high reset
//   dna        in   device ID, stable once dna_valid=1
//   dna_valid  in   device ID readout complete
//   en         in   key shift enable (asynchronous)
//   sclk       in   key serial clock (asynchronous)
//   sdat       in   key serial data (asynchronous)
//   key_ok     out  registered compare result
//   wd_reset   out  reset request, pulse per strike or level when locked
//   strikes    out  consecutive strike count, saturating
//   locked     out  lockout indicator

module key_watchdog_ctrl #(
    parameter int KEY_BITS       = 57,
    parameter int SHIFT_BITS     = 64,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int PULSE_CYCLES   = 16,
    parameter int MAX_STRIKES    = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [KEY_BITS-1:0]                dna,
    input  logic                               dna_valid,
    input  logic                               en,
    input  logic                               sclk,
    input  logic                               sdat,
    output logic                               key_ok,
    output logic                               wd_reset,
    output logic [$clog2(MAX_STRIKES+2)-1:0]   strikes,
    output logic                               locked
);

    // state   | meaning
    // S_WAIT  | device ID not yet valid; timer idle
    // S_RUN   | counting the timeout window, refreshed by key_ok
    // S_PULSE | wd_reset pulse for one strike
    // S_LOCK  | strike limit reached; wd_reset held until rst

    localparam int SW = $clog2(MAX_STRIKES + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int PW = $clog2(PULSE_CYCLES + 1);

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [SW-1:0] S_ONE  = SW'(1);
    localparam logic [SW-1:0] S_SAT  = {SW{1'b1}};
    localparam logic [SW-1:0] S_MAX  = SW'(MAX_STRIKES);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_RUN   = 2'd1,
        S_PULSE = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

    state_t              state;
    logic [TW-1:0]       timer;
    logic [PW-1:0]       pulse_cnt;

    logic [1:0]          en_sync;
    logic [1:0]          sclk_sync;
    logic [1:0]          sdat_sync;
    logic                sclk_prev;
    logic                sclk_rise;
    logic [SHIFT_BITS-1:0] sr;
    logic [SW-1:0]       strikes_inc;

    // The oldest shift bit only ages out of the register; it never reaches
    // the compare.
    logic                unused_sr_msb;
    assign unused_sr_msb = sr[SHIFT_BITS-1];

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;

    // Saturating increment of the strike counter.
    assign strikes_inc = (strikes == S_SAT) ? strikes : (strikes + S_ONE);

    // Serial key capture and compare. dna/dna_valid come from the on-chip
    // ID reader in this clock domain, so they are used directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_sync   <= '0;
            sclk_sync <= '0;
            sdat_sync <= '0;
            sclk_prev <= 1'b0;
            sr        <= '0;
            key_ok    <= 1'b0;
        end else begin
            en_sync   <= {en_sync[0], en};
            sclk_sync <= {sclk_sync[0], sclk};
            sdat_sync <= {sdat_sync[0], sdat};
            sclk_prev <= sclk_sync[1];
            if (sclk_rise && en_sync[1]) begin
                sr <= {sr[SHIFT_BITS-2:0], sdat_sync[1]};
            end
            key_ok <= dna_valid && (sr[KEY_BITS-1:0] == dna);
        end
    end

    // Watchdog FSM with registered outputs. wd_reset and locked are
    // assigned alongside every state transition so they track the state
    // register exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_WAIT;
            timer     <= '0;
            pulse_cnt <= '0;
            strikes   <= '0;
            wd_reset  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    timer    <= '0;
                    wd_reset <= 1'b0;
                    locked   <= 1'b0;
                    if (dna_valid) begin
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    wd_reset <= 1'b0;
                    locked   <= 1'b0;
                    if (!dna_valid) begin
                        state <= S_WAIT;
                        timer <= '0;
                    end else if (key_ok) begin
                        // A match on the timeout cycle itself still wins.
                        timer   <= '0;
                        strikes <= '0;
                    end else if (timer == T_LAST) begin
                        timer     <= '0;
                        strikes   <= strikes_inc;
                        pulse_cnt <= '0;
                        state     <= S_PULSE;
                        wd_reset  <= 1'b1;
                    end else begin
                        timer <= timer + T_ONE;
                    end
                end

                S_PULSE: begin
                    // key_ok and dna_valid are deliberately ignored here.
                    if (pulse_cnt == P_LAST) begin
                        pulse_cnt <= '0;
                        if ((MAX_STRIKES != 0) && (strikes >= S_MAX)) begin
                            state    <= S_LOCK;
                            wd_reset <= 1'b1;
                            locked   <= 1'b1;
                        end else begin
                            state    <= S_RUN;
                            timer    <= '0;
                            wd_reset <= 1'b0;
                        end
                    end else begin
                        pulse_cnt <= pulse_cnt + P_ONE;
                        wd_reset  <= 1'b1;
                    end
                end

                S_LOCK: begin
                    wd_reset <= 1'b1;
                    locked   <= 1'b1;
                end

                default: begin
                    state    <= S_WAIT;
                    timer    <= '0;
                    wd_reset <= 1'b0;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_watchdog_ctrl.sv
// Testbench for key_watchdog_ctrl with a small configuration
// (KEY_BITS=8, SHIFT_BITS=12, TIMEOUT_CYCLES=100, PULSE_CYCLES=4,
// MAX_STRIKES=2). Expected output sets are queued when the stimulus is
// driven and popped when the DUT outputs are sampled on the falling edge.

module tb_key_watchdog_ctrl;

    localparam int KB = 8;
    localparam int SB = 12;
    localparam int TO = 100;
    localparam int PC = 4;
    localparam int MS = 2;

    logic          clk;
    logic          rst;
    logic [KB-1:0] dna;
    logic          dna_valid;
    logic          en;
    logic          sclk;
    logic          sdat;
    logic          key_ok;
    logic          wd_reset;
    logic [1:0]    strikes;
    logic          locked;

    key_watchdog_ctrl #(
        .KEY_BITS       (KB),
        .SHIFT_BITS     (SB),
        .TIMEOUT_CYCLES (TO),
        .PULSE_CYCLES   (PC),
        .MAX_STRIKES    (MS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dna       (dna),
        .dna_valid (dna_valid),
        .en        (en),
        .sclk      (sclk),
        .sdat      (sdat),
        .key_ok    (key_ok),
        .wd_reset  (wd_reset),
        .strikes   (strikes),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         chk_ko;
        bit         chk_wr;
        bit         chk_st;
        bit         chk_lk;
        logic       ko;
        logic       wr;
        logic [1:0] st;
        logic       lk;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Field value -1 means "don't care".
    task automatic push_exp(input string tag, input int ko, input int wr,
                            input int st, input int lk);
        exp_t e;
        e.tag    = tag;
        e.chk_ko = (ko >= 0);
        e.chk_wr = (wr >= 0);
        e.chk_st = (st >= 0);
        e.chk_lk = (lk >= 0);
        e.ko     = ko[0];
        e.wr     = wr[0];
        e.st     = st[1:0];
        e.lk     = lk[0];
        sb_q.push_back(e);
    endtask

    task automatic check_exp();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed no entry, expected one");
            return;
        end
        e = sb_q.pop_front();
        if (e.chk_ko) begin
            checks++;
            assert (key_ok === e.ko) else begin
                errors++;
                $error("FAIL %s key_ok: observed %b expected %b", e.tag, key_ok, e.ko);
            end
        end
        if (e.chk_wr) begin
            checks++;
            assert (wd_reset === e.wr) else begin
                errors++;
                $error("FAIL %s wd_reset: observed %b expected %b", e.tag, wd_reset, e.wr);
            end
        end
        if (e.chk_st) begin
            checks++;
            assert (strikes === e.st) else begin
                errors++;
                $error("FAIL %s strikes: observed %0d expected %0d", e.tag, strikes, e.st);
            end
        end
        if (e.chk_lk) begin
            checks++;
            assert (locked === e.lk) else begin
                errors++;
                $error("FAIL %s locked: observed %b expected %b", e.tag, locked, e.lk);
            end
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        sdat = b;
        sclk = 1'b1;
        step(4);
        sclk = 1'b0;
        step(4);
    endtask

    task automatic shift_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) shift_bit(v[i]);
    endtask

    // Releases rst on a falling edge; the next rising edge is the first
    // clocked cycle out of reset.
    task automatic do_reset(input logic dv);
        rst       = 1'b1;
        sclk      = 1'b0;
        sdat      = 1'b0;
        en        = 1'b1;
        dna_valid = dv;
        step(2);
        rst = 1'b0;
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            step(1);
            if (wd_reset) hi++;
        end
    endtask

    // Steps until wd_reset is seen high or the bound expires.
    task automatic wait_rise(input int bound, output int n);
        n = 0;
        while (!wd_reset && n < bound) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] key;
        int         hi;
        int         n;

        key       = 8'hA5;
        dna       = key;
        rst       = 1'b1;
        dna_valid = 1'b0;
        en        = 1'b0;
        sclk      = 1'b0;
        sdat      = 1'b0;
        step(3);
        push_exp("reset", 0, 0, 0, 0);
        check_exp();

        // Valid key: latency of key_ok, then no pulse for 1000 cycles.
        do_reset(1'b1);
        for (int i = 7; i >= 1; i--) shift_bit(key[i]);
        sdat = key[0];
        sclk = 1'b1;
        step(3);
        push_exp("t1_latency_pre", 0, 0, 0, 0);
        check_exp();
        step(1);
        push_exp("t1_latency", 1, 0, 0, 0);
        check_exp();
        step(3);
        sclk = 1'b0;
        step(4);
        count_high(1000, hi);
        check_int("t1_no_pulse_cycles", hi, 0);
        push_exp("t1_end", 1, 0, 0, 0);
        check_exp();

        // Edges with en=0 are ignored; one enabled edge breaks the match.
        en = 1'b0;
        shift_byte(8'h00);
        push_exp("t5_en_low", 1, 0, 0, 0);
        check_exp();
        en = 1'b1;
        shift_bit(1'b0);
        push_exp("t5_en_high", 0, 0, 0, 0);
        check_exp();

        // No key: two strikes, then lockout held through a valid key.
        do_reset(1'b1);
        step(100);
        push_exp("t2_before_timeout", 0, 0, 0, 0);
        check_exp();
        step(1);
        push_exp("t2_rise", 0, 1, 1, 0);
        check_exp();
        step(3);
        push_exp("t2_pulse_last", 0, 1, 1, 0);
        check_exp();
        step(1);
        push_exp("t2_fall", 0, 0, 1, 0);
        check_exp();
        step(99);
        push_exp("t3_before_timeout", 0, 0, 1, 0);
        check_exp();
        step(1);
        push_exp("t3_rise", 0, 1, 2, 0);
        check_exp();
        step(3);
        push_exp("t3_pulse_last", 0, 1, 2, 0);
        check_exp();
        step(1);
        push_exp("t3_locked", 0, 1, 2, 1);
        check_exp();
        shift_byte(key);
        step(10);
        push_exp("t3_key_no_release", 1, 1, 2, 1);
        check_exp();
        count_high(200, hi);
        check_int("t3_lock_held_cycles", hi, 200);
        rst = 1'b1;
        step(1);
        push_exp("t3_rst_clears", 0, 0, 0, 0);
        check_exp();

        // One strike, then a valid key clears it; the next miss pulses
        // again without lockout.
        do_reset(1'b1);
        step(101);
        push_exp("t4_strike1", 0, 1, 1, 0);
        check_exp();
        step(4);
        push_exp("t4_pulse_end", 0, 0, 1, 0);
        check_exp();
        shift_byte(key);
        step(4);
        push_exp("t4_key_clears", 1, 0, 0, 0);
        check_exp();
        shift_bit(1'b0);
        wait_rise(300, n);
        check_int("t4_window_cycles", n, 96);
        push_exp("t4_strike_again", 0, 1, 1, 0);
        check_exp();
        step(4);
        push_exp("t4_no_lock", 0, 0, 1, 0);
        check_exp();

        // key_ok rises exactly on the timeout cycle: match wins.
        do_reset(1'b1);
        step(40);
        for (int i = 7; i >= 1; i--) shift_bit(key[i]);
        sdat = key[0];
        sclk = 1'b1;
        step(3);
        push_exp("t6_pre", 0, 0, 0, 0);
        check_exp();
        step(1);
        push_exp("t6_key_ok", 1, 0, 0, 0);
        check_exp();
        step(1);
        push_exp("t6_no_pulse", 1, 0, 0, 0);
        check_exp();
        step(3);
        sclk = 1'b0;
        step(4);
        shift_bit(1'b0);
        wait_rise(300, n);
        check_int("t6_timer_restart_cycles", n, 96);

        // dna_valid=0: no pulse and no match.
        do_reset(1'b0);
        shift_byte(key);
        step(5);
        push_exp("t7_key_gated", 0, 0, 0, 0);
        check_exp();
        count_high(300, hi);
        check_int("t7_no_pulse_cycles", hi, 0);

        // rst in the middle of a pulse.
        do_reset(1'b1);
        step(102);
        push_exp("t8_mid_pulse", 0, 1, 1, 0);
        check_exp();
        rst = 1'b1;
        step(1);
        push_exp("t8_rst", 0, 0, 0, 0);
        check_exp();
        rst = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
